// File: rtl/audio_source_scheduler.sv
// audio_source_scheduler
// Sample-rate strobe generator, stereo source capture and click-free gain
// ramp feeding the PCM5102 serializer.
// Build option: define UNDERRUN_CNT_EN to build the saturating underrun
// counter; otherwise underrun_cnt is tied to zero.
// SRC_LAT must be at least 1.
module audio_source_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 1000,
  parameter int SRC_LAT    = 2,
  parameter int RAMP_LOG2  = 6
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         enable,
  input  logic                         mute,
  input  logic                         sel,
  output logic                         sample_ce,
  input  logic signed [DATA_WIDTH-1:0] src0_left,
  input  logic signed [DATA_WIDTH-1:0] src0_right,
  input  logic                         src0_valid,
  input  logic signed [DATA_WIDTH-1:0] src1_left,
  input  logic signed [DATA_WIDTH-1:0] src1_right,
  input  logic                         src1_valid,
  output logic signed [DATA_WIDTH-1:0] left,
  output logic signed [DATA_WIDTH-1:0] right,
  output logic                         out_valid,
  output logic                         cur_src,
  output logic [2:0]                   state_dbg,
  output logic [15:0]                  underrun_cnt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam int GW = RAMP_LOG2 + 1;
  localparam logic [GW-1:0] GAIN_MAX = GW'(2 ** RAMP_LOG2);
  localparam int PW = DATA_WIDTH + RAMP_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SWITCH    = 3'd1,
    RAMP_UP   = 3'd2,
    PLAY      = 3'd3,
    RAMP_DOWN = 3'd4,
    MUTED     = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [CW-1:0]       count;
  logic [SRC_LAT-1:0]  ce_pipe;
  logic                capture;
  logic                scale_ce;
  logic [GW-1:0]       gain;
  logic                gain_inc, gain_dec, gain_clr, load_src;
  logic                src_valid;
  logic                abort;

  logic signed [DATA_WIDTH-1:0] src0_ch [2];
  logic signed [DATA_WIDTH-1:0] src1_ch [2];
  logic signed [DATA_WIDTH-1:0] out_ch  [2];

  assign src0_ch[0] = src0_left;
  assign src0_ch[1] = src0_right;
  assign src1_ch[0] = src1_left;
  assign src1_ch[1] = src1_right;
  assign left       = out_ch[0];
  assign right      = out_ch[1];
  assign state_dbg  = state;

  // Sample-period divider, free running in every state
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)               count <= '0;
    else if (count == LAST)  count <= '0;
    else                     count <= count + 1'b1;
  end

  assign sample_ce = (count == LAST);

  // Delay sample_ce by the source latency to get the capture strobe,
  // then one more cycle for the scaling strobe
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ce_pipe  <= '0;
      scale_ce <= 1'b0;
    end else begin
      ce_pipe[0] <= sample_ce;
      for (int i = 1; i < SRC_LAT; i++) ce_pipe[i] <= ce_pipe[i-1];
      scale_ce <= capture;
    end
  end

  assign capture   = ce_pipe[SRC_LAT-1];
  assign src_valid = cur_src ? src1_valid : src0_valid;

  // Per-channel hold register and gain scaling stage
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] held_q;
    logic signed [DATA_WIDTH-1:0] out_q;
    logic signed [PW-1:0]         held_ext, gain_ext, prod, scaled;

    // Latch the routed source on capture; an underrun keeps the last sample
    always_ff @(posedge clk or negedge arst) begin
      if (!arst)                        held_q <= '0;
      else if (capture && src_valid)    held_q <= cur_src ? src1_ch[gi] : src0_ch[gi];
    end

    // Signed product with the current gain, floor-divided by the full-scale gain
    always_comb begin
      held_ext = PW'(held_q);
      gain_ext = $signed(PW'(gain));
      prod     = held_ext * gain_ext;
      scaled   = prod >>> RAMP_LOG2;
    end

    // Registered output sample
    always_ff @(posedge clk or negedge arst) begin
      if (!arst)         out_q <= '0;
      else if (scale_ce) out_q <= scaled[DATA_WIDTH-1:0];
    end

    assign out_ch[gi] = out_q;
  end

  // Output strobe aligned with the left/right update
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) out_valid <= 1'b0;
    else       out_valid <= scale_ce;
  end

  // FSM state register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_next;
  end

  assign abort = !enable || mute || (sel != cur_src);

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (enable && !mute) state_next = SWITCH;
      SWITCH:    state_next = RAMP_UP;
      RAMP_UP: begin
        if (abort)                                          state_next = RAMP_DOWN;
        else if (scale_ce && gain == GAIN_MAX - 1'b1)       state_next = PLAY;
      end
      PLAY:      if (abort) state_next = RAMP_DOWN;
      RAMP_DOWN: begin
        if (gain == '0) begin
          if (!enable)   state_next = IDLE;
          else if (mute) state_next = MUTED;
          else           state_next = SWITCH;
        end
      end
      MUTED: begin
        if (!enable)    state_next = IDLE;
        else if (!mute) state_next = SWITCH;
      end
      default:   state_next = IDLE;
    endcase
  end

  // FSM outputs: gain stepping happens only when the sample product is taken
  always_comb begin
    gain_inc = 1'b0;
    gain_dec = 1'b0;
    gain_clr = 1'b0;
    load_src = 1'b0;
    unique case (state)
      IDLE, MUTED: gain_clr = 1'b1;
      SWITCH:      load_src = 1'b1;
      RAMP_UP:     gain_inc = scale_ce && (gain != GAIN_MAX);
      RAMP_DOWN:   gain_dec = scale_ce && (gain != '0);
      default:     ;
    endcase
  end

  // Gain and routed-source registers; source only changes at zero gain
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      gain    <= '0;
      cur_src <= 1'b0;
    end else begin
      if (gain_clr)      gain <= '0;
      else if (gain_inc) gain <= gain + 1'b1;
      else if (gain_dec) gain <= gain - 1'b1;
      if (load_src)      cur_src <= sel;
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [15:0] urun;

  // Saturating count of captures that found the routed source not ready
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                                         urun <= '0;
    else if (load_src)                                 urun <= '0;
    else if (capture && !src_valid && urun != 16'hFFFF) urun <= urun + 1'b1;
  end

  assign underrun_cnt = urun;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_source_scheduler.sv
// Directed testbench for audio_source_scheduler (short sample period).
module tb_audio_source_scheduler;

  localparam int DW      = 16;
  localparam int CLK_DIV = 20;
  localparam int SRC_LAT = 2;
  localparam int RL      = 6;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic enable = 1'b0, mute = 1'b0, sel = 1'b0;
  logic [DW-1:0] src0_left = '0, src0_right = '0, src1_left = '0, src1_right = '0;
  logic src0_valid = 1'b0, src1_valid = 1'b0;
  logic sample_ce, out_valid, cur_src;
  logic signed [DW-1:0] left, right;
  logic [2:0] state_dbg;
  logic [15:0] underrun_cnt;

  int tests = 0;
  int fails = 0;

  audio_source_scheduler #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .SRC_LAT(SRC_LAT), .RAMP_LOG2(RL)) dut (
    .clk(clk), .arst(arst), .enable(enable), .mute(mute), .sel(sel),
    .sample_ce(sample_ce),
    .src0_left(src0_left), .src0_right(src0_right), .src0_valid(src0_valid),
    .src1_left(src1_left), .src1_right(src1_right), .src1_valid(src1_valid),
    .left(left), .right(right), .out_valid(out_valid), .cur_src(cur_src),
    .state_dbg(state_dbg), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected output: floor(v * g / 2^RL), truncated to the sample width
  function automatic logic [DW-1:0] scale(input int v, input int g);
    int p;
    p = (v * g) >>> RL;
    return p[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * CLK_DIV; n++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ce(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * CLK_DIV; n++) begin
      tick();
      if (sample_ce) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    arst = 1'b0;
    repeat (3) tick();
    tests++;
    if ({left, right} !== '0) begin
      $display("FAIL reset_lr: got %h/%h want 0/0", left, right); fails++;
    end
    tests++;
    if ({out_valid, sample_ce, cur_src, state_dbg, underrun_cnt} !== '0) begin
      $display("FAIL reset_ctl: got ov=%b ce=%b src=%b st=%0d ur=%0d want all 0",
               out_valid, sample_ce, cur_src, state_dbg, underrun_cnt); fails++;
    end
    @(negedge clk);
    arst = 1'b1;
    n = 0;
    while (!sample_ce && n < 3 * CLK_DIV) begin tick(); n++; end
    tests++;
    if (n != CLK_DIV - 1) begin
      $display("FAIL first_ce: got %0d cycles want %0d", n, CLK_DIV - 1); fails++;
    end
    n = 0;
    do begin tick(); n++; end while (!sample_ce && n < 3 * CLK_DIV);
    tests++;
    if (n != CLK_DIV) begin
      $display("FAIL ce_period: got %0d cycles want %0d", n, CLK_DIV); fails++;
    end
    tests++;
    if (state_dbg !== 3'd0 || left !== '0) begin
      $display("FAIL idle_state: got st=%0d left=%h want st=0 left=0", state_dbg, left); fails++;
    end
  endtask

  task automatic test_ramp_up();
    bit ok;
    int g;
    src0_left = 16'h4000; src0_right = 16'h2000; src0_valid = 1'b1; sel = 1'b0;
    wait_out(ok);
    enable = 1'b1;
    for (int i = 0; i <= 66; i++) begin
      g = (i < 64) ? i : 64;
      wait_ce(ok);
      tests++;
      if (!ok) begin $display("FAIL ramp_ce_timeout: sample %0d", i); fails++; end
      repeat (SRC_LAT + 1) tick();
      tests++;
      if (out_valid !== 1'b0) begin
        $display("FAIL ramp_early_ov: sample %0d got %b want 0", i, out_valid); fails++;
      end
      tick();
      tests++;
      if (out_valid !== 1'b1) begin
        $display("FAIL ramp_latency: sample %0d got ov=%b want 1", i, out_valid); fails++;
      end
      tests++;
      if (left !== scale(16384, g) || right !== scale(8192, g)) begin
        $display("FAIL ramp_up: sample %0d got %h/%h want %h/%h", i, left, right,
                 scale(16384, g), scale(8192, g)); fails++;
      end
    end
    tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL ramp_play: got st=%0d want 3", state_dbg); fails++;
    end
  endtask

  task automatic test_switch();
    bit ok;
    logic [DW-1:0] el, er;
    src1_left = 16'hC000; src1_right = 16'h6000; src1_valid = 1'b1;
    wait_out(ok);
    sel = 1'b1;
    for (int j = 0; j <= 128; j++) begin
      wait_out(ok);
      if (j < 64) begin
        el = scale(16384, 64 - j); er = scale(8192, 64 - j);
      end else begin
        el = scale(-16384, j - 64); er = scale(24576, j - 64);
      end
      tests++;
      if (!ok || left !== el || right !== er) begin
        $display("FAIL switch: sample %0d got %h/%h want %h/%h ok=%b", j, left, right, el, er, ok); fails++;
      end
      tests++;
      if (cur_src !== (j >= 64)) begin
        $display("FAIL switch_src: sample %0d got %b want %b", j, cur_src, (j >= 64)); fails++;
      end
      if (j == 30) sel = 1'b0;
      if (j == 33) sel = 1'b1;
    end
    tests++;
    if (state_dbg !== 3'd3 || left !== 16'hC000) begin
      $display("FAIL switch_end: got st=%0d left=%h want 3/c000", state_dbg, left); fails++;
    end
  endtask

  task automatic test_mute();
    bit ok;
    wait_out(ok);
    enable = 1'b0; sel = 1'b0;
    for (int j = 0; j <= 64; j++) begin
      wait_out(ok);
      tests++;
      if (!ok || left !== scale(-16384, 64 - j) || right !== scale(24576, 64 - j)) begin
        $display("FAIL disable_down: sample %0d got %h/%h want %h/%h", j, left, right,
                 scale(-16384, 64 - j), scale(24576, 64 - j)); fails++;
      end
    end
    tests++;
    if (state_dbg !== 3'd0) begin
      $display("FAIL disable_idle: got st=%0d want 0", state_dbg); fails++;
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_out(ok);
      tests++;
      if (!ok || left !== scale(16384, i)) begin
        $display("FAIL mute_pre_up: sample %0d got %h want %h", i, left, scale(16384, i)); fails++;
      end
    end
    mute = 1'b1;
    tick();
    tests++;
    if (state_dbg !== 3'd4) begin
      $display("FAIL mute_down_state: got st=%0d want 4", state_dbg); fails++;
    end
    for (int m = 0; m <= 20; m++) begin
      wait_out(ok);
      tests++;
      if (!ok || left !== scale(16384, 20 - m) || right !== scale(8192, 20 - m)) begin
        $display("FAIL mute_down: sample %0d got %h/%h want %h/%h", m, left, right,
                 scale(16384, 20 - m), scale(8192, 20 - m)); fails++;
      end
    end
    wait_out(ok);
    tests++;
    if (state_dbg !== 3'd5 || left !== '0 || right !== '0) begin
      $display("FAIL muted_hold: got st=%0d %h/%h want 5 0/0", state_dbg, left, right); fails++;
    end
    mute = 1'b0;
    tick();
    tests++;
    if (state_dbg !== 3'd1) begin
      $display("FAIL unmute_switch: got st=%0d want 1", state_dbg); fails++;
    end
    tick();
    tests++;
    if (state_dbg !== 3'd2) begin
      $display("FAIL unmute_rampup: got st=%0d want 2", state_dbg); fails++;
    end
    for (int i = 0; i <= 64; i++) begin
      wait_out(ok);
      tests++;
      if (!ok || left !== scale(16384, i) || right !== scale(8192, i)) begin
        $display("FAIL unmute_up: sample %0d got %h/%h want %h/%h", i, left, right,
                 scale(16384, i), scale(8192, i)); fails++;
      end
    end
    tests++;
    if (state_dbg !== 3'd3) begin
      $display("FAIL unmute_play: got st=%0d want 3", state_dbg); fails++;
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [DW-1:0] d;
    logic [15:0] exp_ur;
    src0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = 16'h1111;
      src0_left = d * 16'(k + 1);
      src0_right = ~src0_left;
      wait_out(ok);
      tests++;
      if (!ok || left !== 16'h4000 || right !== 16'h2000) begin
        $display("FAIL underrun_hold: sample %0d got %h/%h want 4000/2000", k, left, right); fails++;
      end
    end
    src0_valid = 1'b1; src0_left = 16'h1234; src0_right = 16'h0567;
    wait_out(ok);
    tests++;
    if (!ok || left !== 16'h1234 || right !== 16'h0567) begin
      $display("FAIL underrun_recover: got %h/%h want 1234/0567", left, right); fails++;
    end
`ifdef UNDERRUN_CNT_EN
    exp_ur = 16'd3;
`else
    exp_ur = 16'd0;
`endif
    tests++;
    if (underrun_cnt !== exp_ur) begin
      $display("FAIL underrun_cnt: got %0d want %0d", underrun_cnt, exp_ur); fails++;
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    enable = 1'b0;
    for (int j = 0; j < 24; j++) begin
      wait_out(ok);
      tests++;
      if (!ok || left !== scale(4660, 64 - j) || right !== scale(1383, 64 - j)) begin
        $display("FAIL pre_reset_down: sample %0d got %h/%h want %h/%h", j, left, right,
                 scale(4660, 64 - j), scale(1383, 64 - j)); fails++;
      end
    end
    #2;
    arst = 1'b0;
    #1;
    tests++;
    if ({left, right, out_valid, sample_ce, cur_src, state_dbg, underrun_cnt} !== '0) begin
      $display("FAIL async_reset: got %h/%h ov=%b ce=%b src=%b st=%0d ur=%0d want all 0",
               left, right, out_valid, sample_ce, cur_src, state_dbg, underrun_cnt); fails++;
    end
    enable = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    arst = 1'b1;
    enable = 1'b0;
    n = 0;
    while (!sample_ce && n < 3 * CLK_DIV) begin tick(); n++; end
    tests++;
    if (n != CLK_DIV - 1) begin
      $display("FAIL reset_divider: got %0d cycles want %0d", n, CLK_DIV - 1); fails++;
    end
    tests++;
    if (state_dbg !== 3'd0 || left !== '0) begin
      $display("FAIL reset_idle: got st=%0d left=%h want 0/0", state_dbg, left); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_switch();
    test_mute();
    test_underrun();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
